// File: rtl/lv_efuse_ctrl_if.sv
// Core-side eFuse request/response bundle between the LV core and the eFuse sequencer.
interface lv_efuse_ctrl_if #(
    parameter int unsigned ADDR_W = 2
);
    logic              i_efuse_wmode;
    logic              i_efuse_wr_p;
    logic              i_efuse_rd_p;
    logic              i_efuse_load_req;
    logic [ADDR_W-1:0] i_efuse_addr;
    logic [7:0]        i_efuse_wdata0, i_efuse_wdata1, i_efuse_wdata2, i_efuse_wdata3;
    logic [7:0]        i_efuse_wdata4, i_efuse_wdata5, i_efuse_wdata6, i_efuse_wdata7;
    logic              o_efuse_op_finish;
    logic              o_efuse_reg_update;
    logic              o_efuse_load_done;
    logic              o_efuse_wr_reject;
    logic              o_efuse_busy;
    logic [7:0]        o_efuse_reg_data0, o_efuse_reg_data1, o_efuse_reg_data2, o_efuse_reg_data3;
    logic [7:0]        o_efuse_reg_data4, o_efuse_reg_data5, o_efuse_reg_data6, o_efuse_reg_data7;

    modport master (
        output i_efuse_wmode, i_efuse_wr_p, i_efuse_rd_p, i_efuse_load_req, i_efuse_addr,
               i_efuse_wdata0, i_efuse_wdata1, i_efuse_wdata2, i_efuse_wdata3,
               i_efuse_wdata4, i_efuse_wdata5, i_efuse_wdata6, i_efuse_wdata7,
        input  o_efuse_op_finish, o_efuse_reg_update, o_efuse_load_done, o_efuse_wr_reject,
               o_efuse_busy,
               o_efuse_reg_data0, o_efuse_reg_data1, o_efuse_reg_data2, o_efuse_reg_data3,
               o_efuse_reg_data4, o_efuse_reg_data5, o_efuse_reg_data6, o_efuse_reg_data7
    );

    modport slave (
        input  i_efuse_wmode, i_efuse_wr_p, i_efuse_rd_p, i_efuse_load_req, i_efuse_addr,
               i_efuse_wdata0, i_efuse_wdata1, i_efuse_wdata2, i_efuse_wdata3,
               i_efuse_wdata4, i_efuse_wdata5, i_efuse_wdata6, i_efuse_wdata7,
        output o_efuse_op_finish, o_efuse_reg_update, o_efuse_load_done, o_efuse_wr_reject,
               o_efuse_busy,
               o_efuse_reg_data0, o_efuse_reg_data1, o_efuse_reg_data2, o_efuse_reg_data3,
               o_efuse_reg_data4, o_efuse_reg_data5, o_efuse_reg_data6, o_efuse_reg_data7
    );
endinterface

// File: rtl/lv_efuse_ctrl.sv
// eFuse sequencer: bit-serial programming and byte-serial bank read/load of a fuse macro.
module lv_efuse_ctrl #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned PGM_CYC   = 16,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned RD_CYC    = 3,
    parameter int unsigned LOAD_BANK = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    lv_efuse_ctrl_if.slave    bus,
    output logic              o_fuse_pgm,
    output logic              o_fuse_rd,
    output logic [ADDR_W+5:0] o_fuse_a,
    input  logic [7:0]        i_fuse_q
);
    localparam int unsigned MAX_PG  = (PGM_CYC > GAP_CYC) ? PGM_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_PG > RD_CYC) ? MAX_PG : RD_CYC;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned CNT_W   = 7;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PGM_SCAN = 3'd1;
    localparam logic [2:0] S_PGM_STB  = 3'd2;
    localparam logic [2:0] S_PGM_GAP  = 3'd3;
    localparam logic [2:0] S_RD_STB   = 3'd4;
    localparam logic [2:0] S_RD_CAP   = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    logic [2:0]        r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [TMR_W-1:0]  r_tmr, w_tmr;
    logic [ADDR_W-1:0] r_bank, w_bank;
    logic [63:0]       r_wd, w_wd;
    logic [63:0]       r_shadow, w_shadow;
    logic [63:0]       r_reg, w_reg;
    logic              r_is_load, w_is_load;
    logic              r_is_read, w_is_read;
    logic              r_pgm, w_pgm;
    logic              r_rd, w_rd;
    logic [ADDR_W+5:0] r_a, w_a;
    logic              r_fin, w_fin;
    logic              r_upd, w_upd;
    logic              r_done, w_done;
    logic              r_rej, w_rej;
    logic              r_busy, w_busy;

    // Next-state, datapath and registered-output decode
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_tmr     = r_tmr;
        w_bank    = r_bank;
        w_wd      = r_wd;
        w_shadow  = r_shadow;
        w_reg     = r_reg;
        w_is_load = r_is_load;
        w_is_read = r_is_read;
        w_fin     = 1'b0;
        w_upd     = 1'b0;
        w_done    = 1'b0;
        w_rej     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_efuse_load_req) begin
                    w_state   = S_RD_STB;
                    w_bank    = ADDR_W'(LOAD_BANK);
                    w_is_load = 1'b1;
                    w_is_read = 1'b1;
                    w_cnt     = '0;
                    w_tmr     = TMR_W'(RD_CYC - 1);
                end else if (bus.i_efuse_rd_p) begin
                    w_state   = S_RD_STB;
                    w_bank    = bus.i_efuse_addr;
                    w_is_load = 1'b0;
                    w_is_read = 1'b1;
                    w_cnt     = '0;
                    w_tmr     = TMR_W'(RD_CYC - 1);
                end else if (bus.i_efuse_wr_p) begin
                    if (bus.i_efuse_wmode) begin
                        w_state   = S_PGM_SCAN;
                        w_bank    = bus.i_efuse_addr;
                        w_wd      = {bus.i_efuse_wdata7, bus.i_efuse_wdata6, bus.i_efuse_wdata5,
                                     bus.i_efuse_wdata4, bus.i_efuse_wdata3, bus.i_efuse_wdata2,
                                     bus.i_efuse_wdata1, bus.i_efuse_wdata0};
                        w_is_load = 1'b0;
                        w_is_read = 1'b0;
                        w_cnt     = '0;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
            end
            S_PGM_SCAN: begin
                if (r_wd[r_cnt[5:0]]) begin
                    w_state = S_PGM_STB;
                    w_tmr   = TMR_W'(PGM_CYC - 1);
                end else if (r_cnt == CNT_W'(63)) begin
                    w_state = S_FIN;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_PGM_STB: begin
                if (r_tmr == '0) begin
                    w_state = S_PGM_GAP;
                    w_tmr   = TMR_W'(GAP_CYC - 1);
                end else begin
                    w_tmr = r_tmr - TMR_W'(1);
                end
            end
            S_PGM_GAP: begin
                if (r_tmr != '0) begin
                    w_tmr = r_tmr - TMR_W'(1);
                end else if (r_cnt == CNT_W'(63)) begin
                    w_state = S_FIN;
                end else begin
                    w_state = S_PGM_SCAN;
                    w_cnt   = r_cnt + CNT_W'(1);
                end
            end
            S_RD_STB: begin
                if (r_tmr == '0) begin
                    w_state = S_RD_CAP;
                end else begin
                    w_tmr = r_tmr - TMR_W'(1);
                end
            end
            S_RD_CAP: begin
                w_shadow[{r_cnt[2:0], 3'b000} +: 8] = i_fuse_q;
                if (r_cnt == CNT_W'(7)) begin
                    w_state = S_FIN;
                end else begin
                    w_state = S_RD_STB;
                    w_cnt   = r_cnt + CNT_W'(1);
                    w_tmr   = TMR_W'(RD_CYC - 1);
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
                w_fin   = ~r_is_load;
                w_done  = r_is_load;
                w_upd   = r_is_read;
                if (r_is_read) begin
                    w_reg = r_shadow;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Strobes and address follow the state being entered so they register in step with it
        w_pgm  = (w_state == S_PGM_STB);
        w_rd   = (w_state == S_RD_STB);
        w_busy = (w_state != S_IDLE);
        case (w_state)
            S_PGM_STB, S_PGM_GAP: w_a = {w_bank, w_cnt[5:0]};
            S_RD_STB, S_RD_CAP:   w_a = {w_bank, w_cnt[2:0], 3'b000};
            default:              w_a = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_bank    <= '0;
            r_wd      <= '0;
            r_shadow  <= '0;
            r_reg     <= '0;
            r_is_load <= 1'b0;
            r_is_read <= 1'b0;
            r_pgm     <= 1'b0;
            r_rd      <= 1'b0;
            r_a       <= '0;
            r_fin     <= 1'b0;
            r_upd     <= 1'b0;
            r_done    <= 1'b0;
            r_rej     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_tmr     <= w_tmr;
            r_bank    <= w_bank;
            r_wd      <= w_wd;
            r_shadow  <= w_shadow;
            r_reg     <= w_reg;
            r_is_load <= w_is_load;
            r_is_read <= w_is_read;
            r_pgm     <= w_pgm;
            r_rd      <= w_rd;
            r_a       <= w_a;
            r_fin     <= w_fin;
            r_upd     <= w_upd;
            r_done    <= w_done;
            r_rej     <= w_rej;
            r_busy    <= w_busy;
        end
    end

    assign o_fuse_pgm             = r_pgm;
    assign o_fuse_rd              = r_rd;
    assign o_fuse_a               = r_a;
    assign bus.o_efuse_op_finish  = r_fin;
    assign bus.o_efuse_reg_update = r_upd;
    assign bus.o_efuse_load_done  = r_done;
    assign bus.o_efuse_wr_reject  = r_rej;
    assign bus.o_efuse_busy       = r_busy;
    assign bus.o_efuse_reg_data0  = r_reg[7:0];
    assign bus.o_efuse_reg_data1  = r_reg[15:8];
    assign bus.o_efuse_reg_data2  = r_reg[23:16];
    assign bus.o_efuse_reg_data3  = r_reg[31:24];
    assign bus.o_efuse_reg_data4  = r_reg[39:32];
    assign bus.o_efuse_reg_data5  = r_reg[47:40];
    assign bus.o_efuse_reg_data6  = r_reg[55:48];
    assign bus.o_efuse_reg_data7  = r_reg[63:56];
endmodule

// File: tb/tb_lv_efuse_ctrl.sv
// Bench for lv_efuse_ctrl: fuse macro model, strobe monitor and directed plus random operations.
module tb_lv_efuse_ctrl;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned PGM_CYC = 16;
    localparam int unsigned GAP_CYC = 4;
    localparam int unsigned RD_CYC  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pgm, rd;
    logic [7:0] fa;
    logic [7:0] fq;

    lv_efuse_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lv_efuse_ctrl #(
        .ADDR_W(ADDR_W), .PGM_CYC(PGM_CYC), .GAP_CYC(GAP_CYC), .RD_CYC(RD_CYC), .LOAD_BANK(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_fuse_pgm(pgm), .o_fuse_rd(rd), .o_fuse_a(fa), .i_fuse_q(fq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(input int b);
        case (b)
            0:       return 64'h8877665544332211;
            1:       return 64'h0123456789ABCDEF;
            2:       return 64'hF0E1D2C3B4A59687;
            default: return 64'h0000FFFF0000FFFF;
        endcase
    endfunction

    // Fuse macro: a bit blows only after a full-length program strobe
    logic [63:0] fmem [4];
    bit          mem_init = 1'b0;
    always_comb fq = fmem[fa[7:6]][{fa[5:3], 3'b000} +: 8];

    logic [63:0] rd_all;
    assign rd_all = {bus.o_efuse_reg_data7, bus.o_efuse_reg_data6, bus.o_efuse_reg_data5,
                     bus.o_efuse_reg_data4, bus.o_efuse_reg_data3, bus.o_efuse_reg_data2,
                     bus.o_efuse_reg_data1, bus.o_efuse_reg_data0};

    int         n_fin = 0, n_upd = 0, n_done = 0, n_rej = 0, n_both = 0, n_unst = 0, n_busy = 0;
    int         fin_cyc = 0, rej_cyc = 0;
    logic [7:0] pa_q[$], ra_q[$];
    int         pl_q[$], rl_q[$], gap_q[$];
    bit         p_pgm = 1'b0, p_rd = 1'b0, in_gap = 1'b0;
    logic [7:0] cur_pa = '0, cur_ra = '0;
    int         cur_pl = 0, cur_rl = 0, gap_len = 0;

    // Strobe / pulse monitor sampled mid-cycle
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4; i++) fmem[i] = init_val(i);
            mem_init = 1'b1;
        end
        if (pgm && rd) n_both++;
        if (bus.o_efuse_busy) n_busy++;
        if (bus.o_efuse_op_finish) begin n_fin++; fin_cyc = cyc; end
        if (bus.o_efuse_load_done) begin n_done++; fin_cyc = cyc; end
        if (bus.o_efuse_reg_update) n_upd++;
        if (bus.o_efuse_wr_reject) begin n_rej++; rej_cyc = cyc; end
        if (pgm) begin
            if (!p_pgm) begin cur_pa = fa; cur_pl = 0; end
            else if (fa != cur_pa) n_unst++;
            cur_pl++;
        end else if (p_pgm) begin
            pa_q.push_back(cur_pa);
            pl_q.push_back(cur_pl);
            if (cur_pl >= int'(PGM_CYC)) fmem[cur_pa[7:6]][cur_pa[5:0]] = 1'b1;
            in_gap = 1'b1;
            gap_len = 0;
        end
        if (in_gap) begin
            if (!pgm && bus.o_efuse_busy && fa == cur_pa) gap_len++;
            else begin gap_q.push_back(gap_len); in_gap = 1'b0; end
        end
        if (rd) begin
            if (!p_rd) begin cur_ra = fa; cur_rl = 0; end
            cur_rl++;
        end else if (p_rd) begin
            ra_q.push_back(cur_ra);
            rl_q.push_back(cur_rl);
        end
        p_pgm = pgm;
        p_rd  = rd;
    end

    int          checks = 0, errors = 0;
    logic [63:0] ref_mem [4];
    logic [63:0] exp_reg;
    int          t0, s_fin, s_upd, s_done, s_rej, s_pa, s_ra, s_gap, s_both, s_unst, s_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input bit ld, input bit rp, input bit wp, input bit wm,
                         input logic [1:0] ad, input logic [63:0] wd);
        @(posedge clk); #1;
        bus.i_efuse_load_req = ld; bus.i_efuse_rd_p = rp; bus.i_efuse_wr_p = wp;
        bus.i_efuse_wmode = wm;    bus.i_efuse_addr = ad;
        {bus.i_efuse_wdata7, bus.i_efuse_wdata6, bus.i_efuse_wdata5, bus.i_efuse_wdata4,
         bus.i_efuse_wdata3, bus.i_efuse_wdata2, bus.i_efuse_wdata1, bus.i_efuse_wdata0} = wd;
        @(posedge clk); #1;
        bus.i_efuse_load_req = 1'b0; bus.i_efuse_rd_p = 1'b0; bus.i_efuse_wr_p = 1'b0;
        bus.i_efuse_addr = ~ad;
        {bus.i_efuse_wdata7, bus.i_efuse_wdata6, bus.i_efuse_wdata5, bus.i_efuse_wdata4,
         bus.i_efuse_wdata3, bus.i_efuse_wdata2, bus.i_efuse_wdata1, bus.i_efuse_wdata0} = ~wd;
    endtask

    task automatic drive(input bit ld, input bit rp, input bit wp, input bit wm,
                         input logic [1:0] ad, input logic [63:0] wd);
        s_fin = n_fin; s_upd = n_upd; s_done = n_done; s_rej = n_rej; s_busy = n_busy;
        s_pa = pa_q.size(); s_ra = ra_q.size(); s_gap = gap_q.size();
        s_both = n_both; s_unst = n_unst;
        t0 = cyc + 1;
        pulse(ld, rp, wp, wm, ad, wd);
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while ((n_fin + n_done) == (s_fin + s_done) && k < budget) begin
            @(negedge clk); k++;
        end
        chk("op_timeout", 64'(k < budget), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_read(input logic [1:0] bank, input bit is_load);
        chk("rd_strobe_count", 64'(ra_q.size() - s_ra), 64'd8);
        for (int b = 0; b < 8; b++) begin
            logic [7:0] a_got;
            int         l_got;
            a_got = (s_ra + b < ra_q.size()) ? ra_q[s_ra + b] : 8'hxx;
            l_got = (s_ra + b < rl_q.size()) ? rl_q[s_ra + b] : -1;
            chk($sformatf("rd_addr_b%0d", b), 64'(a_got), 64'({bank, 3'(b), 3'b000}));
            chk($sformatf("rd_len_b%0d", b), 64'(l_got), 64'(RD_CYC));
        end
        exp_reg = ref_mem[bank];
        chk("reg_data", rd_all, exp_reg);
        chk("reg_update_cnt", 64'(n_upd - s_upd), 64'd1);
        chk("op_finish_cnt", 64'(n_fin - s_fin), 64'(!is_load));
        chk("load_done_cnt", 64'(n_done - s_done), 64'(is_load));
        chk("rd_latency", 64'(fin_cyc - t0), 64'(8 * (RD_CYC + 1) + 2));
        chk("rd_no_pgm", 64'(pa_q.size() - s_pa), 64'd0);
        chk("rd_no_overlap", 64'(n_both - s_both), 64'd0);
    endtask

    task automatic check_write(input logic [1:0] bank, input logic [63:0] wd);
        int j = 0;
        for (int i = 0; i < 64; i++) begin
            if (wd[i]) begin
                logic [7:0] a_got;
                int         l_got, g_got;
                a_got = (s_pa + j < pa_q.size()) ? pa_q[s_pa + j] : 8'hxx;
                l_got = (s_pa + j < pl_q.size()) ? pl_q[s_pa + j] : -1;
                g_got = (s_gap + j < gap_q.size()) ? gap_q[s_gap + j] : -1;
                chk($sformatf("pgm_addr_%0d", j), 64'(a_got), 64'({bank, 6'(i)}));
                chk($sformatf("pgm_len_%0d", j), 64'(l_got), 64'(PGM_CYC));
                if ({bank, 6'(i)} != 8'd0)
                    chk($sformatf("pgm_gap_%0d", j), 64'(g_got), 64'(GAP_CYC));
                j++;
            end
        end
        chk("pgm_strobe_count", 64'(pa_q.size() - s_pa), 64'(j));
        chk("wr_finish_cnt", 64'(n_fin - s_fin), 64'd1);
        chk("wr_no_update", 64'(n_upd - s_upd), 64'd0);
        chk("wr_no_done", 64'(n_done - s_done), 64'd0);
        chk("wr_reg_kept", rd_all, exp_reg);
        chk("wr_latency", 64'(fin_cyc - t0), 64'(64 + j * (PGM_CYC + GAP_CYC) + 2));
        chk("wr_no_rd", 64'(ra_q.size() - s_ra), 64'd0);
        chk("wr_a_stable", 64'(n_unst - s_unst), 64'd0);
        chk("wr_no_overlap", 64'(n_both - s_both), 64'd0);
        ref_mem[bank] = ref_mem[bank] | wd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [63:0] wd;
        logic [1:0]  bk;
        for (int i = 0; i < 4; i++) ref_mem[i] = init_val(i);
        exp_reg = '0;
        rst = 1'b1;
        bus.i_efuse_wmode = 1'b0; bus.i_efuse_wr_p = 1'b0; bus.i_efuse_rd_p = 1'b0;
        bus.i_efuse_load_req = 1'b0; bus.i_efuse_addr = '0;
        {bus.i_efuse_wdata7, bus.i_efuse_wdata6, bus.i_efuse_wdata5, bus.i_efuse_wdata4,
         bus.i_efuse_wdata3, bus.i_efuse_wdata2, bus.i_efuse_wdata1, bus.i_efuse_wdata0} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.o_efuse_busy), 64'd0);
        chk("rst_strobes", 64'({pgm, rd}), 64'd0);
        chk("rst_addr", 64'(fa), 64'd0);
        chk("rst_reg_data", rd_all, 64'd0);
        chk("rst_pulses", 64'({bus.o_efuse_op_finish, bus.o_efuse_reg_update,
                               bus.o_efuse_load_done, bus.o_efuse_wr_reject}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Power-up load of bank 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0);
        wait_end(400);
        check_read(2'd0, 1'b1);

        // Program bits 0 and 2 of bank 2
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 64'h05);
        wait_end(400);
        check_write(2'd2, 64'h05);

        // Program refused with wmode low
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, '1);
        repeat (4) @(negedge clk);
        chk("rej_cnt", 64'(n_rej - s_rej), 64'd1);
        chk("rej_timing", 64'(rej_cyc - t0), 64'd1);
        chk("rej_no_pgm", 64'(pa_q.size() - s_pa), 64'd0);
        chk("rej_busy", 64'(n_busy - s_busy), 64'd0);
        chk("rej_no_finish", 64'(n_fin - s_fin), 64'd0);

        // Simultaneous requests: load wins
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, '1);
        wait_end(400);
        check_read(2'd0, 1'b1);

        // Read bank 1 with a second read arriving mid-operation
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 64'd0);
        k = 0;
        while (ra_q.size() - s_ra < 3 && k < 200) begin @(negedge clk); k++; end
        chk("rd_mid_wait", 64'(k < 200), 64'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 64'd0);
        wait_end(400);
        check_read(2'd1, 1'b0);

        // Reset during a program strobe
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, (64'd1 << 10) | (64'd1 << 20));
        k = 0;
        while (!pgm && k < 200) begin @(negedge clk); k++; end
        chk("pgm_start_wait", 64'(k < 200), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_pgm", 64'(pgm), 64'd0);
        chk("rst_mid_busy", 64'(bus.o_efuse_busy), 64'd0);
        exp_reg = '0;
        chk("rst_mid_reg", rd_all, exp_reg);
        repeat (100) @(negedge clk);
        chk("rst_mid_no_fin", 64'(n_fin - s_fin), 64'd0);
        chk("rst_mid_no_upd", 64'(n_upd - s_upd), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 64'd0);
        wait_end(400);
        check_read(2'd3, 1'b0);

        // Random mix of loads, reads and sparse programs
        for (int n = 0; n < 12; n++) begin
            k  = int'($urandom_range(0, 2));
            bk = 2'($urandom_range(0, 3));
            if (k == 0) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, bk, 64'($urandom));
                wait_end(400);
                check_read(2'd0, 1'b1);
            end else if (k == 1) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, bk, 64'($urandom));
                wait_end(400);
                check_read(bk, 1'b0);
            end else begin
                wd = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                drive(1'b0, 1'b0, 1'b1, 1'b1, bk, wd);
                wait_end(2000);
                check_write(bk, wd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
